rc4_search_scheduler: RTL

Parametrised multi-core scheduler for the RC4 key-search datapath. It partitions the key space 0..MAX_KEY across N_CORES decrypt/check cores by interleaving: core c tests keys c, c+N_CORES, c+2·N_CORES, and so on. It issues keys to each core over a start/done handshake, aggregates the results, and aborts all cores when the first one finds the key. It reports found/exhausted status, which drives the board LEDs, and counts keys tested for progress display.

---
 rtl/rc4_search_pkg.sv | 6 +
 rtl/rc4_search_lane.sv | 48 ++++
 rtl/rc4_search_scheduler.sv | 72 +++++++
 3 files changed

// File: rtl/rc4_search_pkg.sv
// rc4_search_pkg: shared state encodings and defaults for the RC4 key-search scheduler
package rc4_search_pkg;
    localparam int DEFAULT_KEY_W = 24;
    typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} g_state_t;
    typedef enum logic [1:0] {L_IDLE, L_BUSY, L_RETIRED} l_state_t;
endpackage

// File: rtl/rc4_search_lane.sv
// rc4_search_lane: one core's key sequence (IDX, IDX+N_CORES, ...) and start/done handshake
module rc4_search_lane
    import rc4_search_pkg::*;
#(
    parameter int KEY_W = DEFAULT_KEY_W,
    parameter int N_CORES = 4,
    parameter logic [KEY_W-1:0] MAX_KEY = '1,
    parameter int IDX = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             run,
    input  logic             done,
    input  logic             found,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    output logic             tested,
    output logic             hit,
    output logic             retired
);
    l_state_t state;
    logic [KEY_W:0] next_key;
    logic eligible;
    assign eligible = next_key <= {1'b0, MAX_KEY};
    assign core_start = run && state == L_IDLE && eligible;
    assign core_key = next_key[KEY_W-1:0];
    assign tested = run && state == L_BUSY && done;
    assign hit = tested && found;
    // counts a lane retiring this cycle so exhaustion is flagged on the same edge
    assign retired = state == L_RETIRED || (run && state == L_IDLE && !eligible);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= L_IDLE;
            next_key <= '0;
        end else if (accept) begin
            state <= L_IDLE;
            next_key <= (KEY_W+1)'(IDX);
        end else if (core_start) begin
            state <= L_BUSY;
        end else if (run && state == L_IDLE) begin
            state <= L_RETIRED;
        end else if (tested && !found) begin
            state <= L_IDLE;
            next_key <= next_key + (KEY_W+1)'(N_CORES);
        end
    end
endmodule

// File: rtl/rc4_search_scheduler.sv
// rc4_search_scheduler: interleaves the key space over N_CORES cores, arbitrates finds, tracks progress
module rc4_search_scheduler
    import rc4_search_pkg::*;
#(
    parameter int KEY_W = DEFAULT_KEY_W,
    parameter int N_CORES = 4,
    parameter logic [KEY_W-1:0] MAX_KEY = KEY_W'(24'h3FFFFF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_CORES-1:0]       core_done,
    input  logic [N_CORES-1:0]       core_found,
    output logic [N_CORES-1:0]       core_start,
    output logic [N_CORES*KEY_W-1:0] core_key,
    output logic                     core_abort,
    output logic                     busy,
    output logic                     key_found,
    output logic                     no_key,
    output logic [KEY_W-1:0]         found_key,
    output logic [KEY_W:0]           keys_tested
);
    g_state_t state;
    logic [N_CORES-1:0] tested, hit, retired;
    logic [KEY_W-1:0] win_key;
    logic [KEY_W+1:0] sum;
    logic accept, run;
    assign accept = start && state != RUN;
    assign run = state == RUN;
    assign busy = run;
    assign key_found = state == FOUND;
    assign no_key = state == EXHAUSTED;
    assign core_abort = key_found || no_key;
    for (genvar c = 0; c < N_CORES; c++) begin : g_lane
        rc4_search_lane #(
            .KEY_W(KEY_W), .N_CORES(N_CORES), .MAX_KEY(MAX_KEY), .IDX(c)
        ) u_lane (
            .clk(clk), .reset(reset), .accept(accept), .run(run),
            .done(core_done[c]), .found(core_found[c]),
            .core_start(core_start[c]), .core_key(core_key[c*KEY_W +: KEY_W]),
            .tested(tested[c]), .hit(hit[c]), .retired(retired[c])
        );
    end
    // descending scan so the lowest-index hit wins
    always_comb begin
        win_key = '0;
        sum = {1'b0, keys_tested};
        for (int i = N_CORES - 1; i >= 0; i--) begin
            win_key = hit[i] ? core_key[i*KEY_W +: KEY_W] : win_key;
            sum = sum + (KEY_W+2)'(tested[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            found_key <= '0;
            keys_tested <= '0;
        end else if (accept) begin
            state <= RUN;
            found_key <= '0;
            keys_tested <= '0;
        end else if (run) begin
            keys_tested <= sum[KEY_W+1] ? '1 : sum[KEY_W:0];
            if (|hit) begin
                state <= FOUND;
                found_key <= win_key;
            end else if (&retired) begin
                state <= EXHAUSTED;
            end
        end
    end
endmodule
